logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
// - Multi-lane, pipelined logic unit for the VLIW execute stage. One lane per issue slot.
// - Performs bitwise and two's-complement operations on WIDTH-bit operands.
// - A registered valid/ready stage lets the writeback arbiter apply backpressure.
// - Illegal opcodes are flagged and counted, never propagated as X.
// PARAMETERS
// - WIDTH   32  operand/result width per lane (>=2)
// - LANES   2   number of parallel lanes (one per VLIW slot, >=1)
// - CNT_W   8   width of the saturating illegal-op counter
// PORTS
// - clk          in   1            rising-edge clock, the only clock
// - rst_n        in   1            asynchronous, active-low reset
// - in_valid     in   1            input beat valid
// - in_ready     out  1            block can accept a beat this cycle
// - in_lane_en   in   LANES        per-lane enable for the beat
// - in_op        in   LANES*5      5-bit opcode per lane; lane i is [5i+4:5i]
// - in_a         in   LANES*WIDTH  operand A per lane
// - in_b         in   LANES*WIDTH  operand B per lane
// - out_valid    out  1            result beat valid
// - out_ready    in   1            downstream accepts the result beat
// - out_c        out  LANES*WIDTH  result per lane
// - out_zero     out  LANES        lane result == 0 (enabled, legal lanes only)
// - out_illegal  out  LANES        lane opcode illegal (enabled lanes only)
// - err_clr      in   1            synchronous clear of err_count
// - err_count    out  CNT_W        accepted beats with >=1 illegal lane; saturates
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0; out_c/out_zero/out_illegal=0; err_count=0.
//   A beat held in the stage at reset is dropped. in_ready=1 on the first cycle after release.
// - Opcodes:
//   - 01010 AND, 01011 OR, 01100 XOR, 01101 NAND, 01110 NOR, 01111 XNOR
//   - 10000 NOT a, 10001 NEG (~a+1, modulo 2^WIDTH)
//   - 10010 ANDN (a&~b), 10011 ORN (a|~b)
//   - 10100 PASSA, 10101 PASSB
//   - 10110 POPC (zero-extended count of ones in a)
//   - all other codes are illegal: c=0, illegal=1, zero=0
// - Disabled lane: c=0, zero=0, illegal=0; does not count as illegal.
// - Handshake:
//   - in_ready = !out_valid | out_ready (combinational; full throughput, 1 beat/cycle).
//   - Accept = in_valid & in_ready. On accept, all lanes are registered together.
//   - Latency is 1 cycle from accept to out_valid.
//   - If out_ready=1 and there is no accept, out_valid falls to 0 on the next edge.
//   - While out_valid=1 and out_ready=0, all out_* hold stable.
//   - Accept with out_ready=1 in the same cycle replaces the beat, with no bubble.
//   - Inputs are ignored when in_valid=0. out_* hold their last value when out_valid=0.
// - err_count:
//   - Increments by 1 on each accept that has any out_illegal lane set.
//   - Holds at 2^CNT_W-1 once reached (saturates).
//   - err_clr has priority. If err_clr and an illegal accept occur in the same cycle, err_count=0.
// - Arithmetic:
//   - NEG wraps: NEG of 0 = 0; NEG of 2^(WIDTH-1) = 2^(WIDTH-1).
//   - POPC of all-ones = WIDTH.
// STRUCTURE
// - Package lu_pkg holds:
//   - localparam opcode constants (LU_AND..LU_POPC)
//   - the lu_op_t 5-bit typedef
//   - a function is_legal_op()
// - Sub-module lu_lane: purely combinational (a, b, op, en) -> (c, zero, illegal).
//   - Parametrised by WIDTH; instantiated LANES times in a generate loop.
// - Top level holds only the output register stage, handshake logic and err_count.
// TESTING
// - Single beat, LANES=2, out_ready=1:
//   - lane0 AND a=F0F0F0F0 b=FF00FF00; lane1 NEG a=00000001.
//   - Next cycle: out_c = {FFFFFFFF, F000F000}; zero=00; illegal=00.
// - Backpressure:
//   - Beat accepted with out_ready=0; in_ready=0 the following cycle.
//   - A second in_valid is held off, and out_* are stable for 3 cycles.
//   - Raise out_ready: the second beat is accepted the same cycle and appears next cycle, with no loss.
// - Illegal and disabled lanes:
//   - lane0 op=11111, lane1 en=0.
//   - Response: out_illegal=01, out_c=0, err_count=1.
//   - 300 such beats with CNT_W=8 -> err_count=FF.
// - Boundaries:
//   - NEG a=80000000 -> 80000000.
//   - POPC a=FFFFFFFF -> 00000020.
//   - XOR a=b -> c=0, zero=1.
// - Clear and reset:
//   - err_clr together with an illegal accept -> err_count=0.
//   - rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 at once, then in_ready=1 after release.
// - Streaming:
//   - 1000 random beats with random in_valid/out_ready.
//   - Scoreboard matches a reference model in order, with no drops or duplicates.

Source files
------------

// File: rtl/lu_pkg.sv
// Package: lu_pkg
// Shared definitions for the pipelined logic unit.
//   lu_op_t       5-bit opcode type
//   LU_AND..LU_POPC  opcode constants; legal codes form one contiguous range
//   is_legal_op() returns 1 for any opcode the lane datapath implements
package lu_pkg;

    typedef logic [4:0] lu_op_t;

    localparam lu_op_t LU_AND   = 5'b01010;
    localparam lu_op_t LU_OR    = 5'b01011;
    localparam lu_op_t LU_XOR   = 5'b01100;
    localparam lu_op_t LU_NAND  = 5'b01101;
    localparam lu_op_t LU_NOR   = 5'b01110;
    localparam lu_op_t LU_XNOR  = 5'b01111;
    localparam lu_op_t LU_NOT   = 5'b10000;
    localparam lu_op_t LU_NEG   = 5'b10001;
    localparam lu_op_t LU_ANDN  = 5'b10010;
    localparam lu_op_t LU_ORN   = 5'b10011;
    localparam lu_op_t LU_PASSA = 5'b10100;
    localparam lu_op_t LU_PASSB = 5'b10101;
    localparam lu_op_t LU_POPC  = 5'b10110;

    // The implemented opcodes are contiguous, so legality is a range test.
    function automatic logic is_legal_op(input lu_op_t op);
        return (op >= LU_AND) && (op <= LU_POPC);
    endfunction

endpackage

// File: rtl/lu_lane.sv
// Module: lu_lane
// Purely combinational datapath for one issue slot.
//   a, b     in   WIDTH  operands
//   op       in   5      opcode (lu_op_t)
//   en       in   1      lane enable; a disabled lane outputs all zeros
//   c        out  WIDTH  result (0 for disabled or illegal lanes)
//   zero     out  1      result is zero on an enabled, legal lane
//   illegal  out  1      opcode illegal on an enabled lane
module lu_lane
    import lu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  lu_op_t           op,
    input  logic             en,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             illegal
);

    logic [WIDTH-1:0] pop;

    // Population count of a, zero-extended; WIDTH >= 2 guarantees it fits.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + WIDTH'(a[i]);
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; without this the tool would infer a latch.
        c       = '0;
        illegal = 1'b0;
        if (en) begin
            illegal = !is_legal_op(op);
            case (op)
                LU_AND:   c = a & b;
                LU_OR:    c = a | b;
                LU_XOR:   c = a ^ b;
                LU_NAND:  c = ~(a & b);
                LU_NOR:   c = ~(a | b);
                LU_XNOR:  c = ~(a ^ b);
                LU_NOT:   c = ~a;
                LU_NEG:   c = ~a + WIDTH'(1);
                LU_ANDN:  c = a & ~b;
                LU_ORN:   c = a | ~b;
                LU_PASSA: c = a;
                LU_PASSB: c = b;
                LU_POPC:  c = pop;
                default:  c = '0;
            endcase
        end
        zero = en && !illegal && (c == '0);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Module: logic_unit_pipe
// Multi-lane logic unit with one registered valid/ready output stage.
//   clk, rst_n    clock and asynchronous active-low reset
//   in_valid      in   input beat valid
//   in_ready      out  stage can take a beat (empty or draining this cycle)
//   in_lane_en    in   per-lane enable
//   in_op         in   5-bit opcode per lane, lane i at [5i+4:5i]
//   in_a, in_b    in   operands per lane, lane i at [WIDTH*i +: WIDTH]
//   out_valid     out  result beat valid
//   out_ready     in   downstream takes the result beat
//   out_c         out  result per lane
//   out_zero      out  per-lane zero flag
//   out_illegal   out  per-lane illegal-opcode flag
//   err_clr       in   synchronous clear of err_count (wins over increment)
//   err_count     out  saturating count of accepted beats with an illegal lane
module logic_unit_pipe
    import lu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_en,
    input  logic [LANES*5-1:0]     in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_c,
    output logic [LANES-1:0]       out_zero,
    output logic [LANES-1:0]       out_illegal,
    input  logic                   err_clr,
    output logic [CNT_W-1:0]       err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LANES*WIDTH-1:0] lane_c;
    logic [LANES-1:0]       lane_zero;
    logic [LANES-1:0]       lane_illegal;
    logic                   accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lu_lane #(.WIDTH(WIDTH)) u_lane (
            .a       (in_a[i*WIDTH +: WIDTH]),
            .b       (in_b[i*WIDTH +: WIDTH]),
            .op      (in_op[i*5 +: 5]),
            .en      (in_lane_en[i]),
            .c       (lane_c[i*WIDTH +: WIDTH]),
            .zero    (lane_zero[i]),
            .illegal (lane_illegal[i])
        );
    end

    // The stage can refill in the same cycle it drains, so no bubble.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_c       <= '0;
            out_zero    <= '0;
            out_illegal <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_c       <= lane_c;
            out_zero    <= lane_zero;
            out_illegal <= lane_illegal;
        end else if (out_ready) begin
            // Data registers keep their last value; only the valid bit drops.
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && (|lane_illegal) && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench: tb_logic_unit_pipe
// Directed and streamed beats into logic_unit_pipe. The driver pushes the
// expected response of each beat into a scoreboard queue at the moment it is
// accepted; an independent monitor pops and compares every beat the DUT hands
// downstream.
module tb_logic_unit_pipe;

    localparam int WIDTH = 32;
    localparam int LANES = 2;
    localparam int CNT_W = 8;

    typedef struct {
        logic [LANES*WIDTH-1:0] c;
        logic [LANES-1:0]       zero;
        logic [LANES-1:0]       ill;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_lane_en;
    logic [LANES*5-1:0]     in_op;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_c;
    logic [LANES-1:0]       out_zero;
    logic [LANES-1:0]       out_illegal;
    logic                   err_clr;
    logic [CNT_W-1:0]       err_count;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane_en  (in_lane_en),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c       (out_c),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .err_clr     (err_clr),
        .err_count   (err_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference for one lane.
    function automatic void ref_lane(input logic en, input logic [4:0] op,
                                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     output logic [WIDTH-1:0] c, output logic z, output logic il);
        c  = '0;
        il = 1'b0;
        if (en) begin
            case (op)
                5'd10: c = a & b;
                5'd11: c = a | b;
                5'd12: c = a ^ b;
                5'd13: c = ~(a & b);
                5'd14: c = ~(a | b);
                5'd15: c = ~(a ^ b);
                5'd16: c = ~a;
                5'd17: c = 32'd0 - a;
                5'd18: c = a & ~b;
                5'd19: c = a | ~b;
                5'd20: c = a;
                5'd21: c = b;
                5'd22: c = WIDTH'($countones(a));
                default: il = 1'b1;
            endcase
        end
        z = en && !il && (c == 0);
    endfunction

    function automatic exp_t ref_beat(input logic [LANES-1:0] en, input logic [LANES*5-1:0] op,
                                      input logic [LANES*WIDTH-1:0] a, input logic [LANES*WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] c;
        logic z, il;
        for (int l = 0; l < LANES; l++) begin
            ref_lane(en[l], op[l*5 +: 5], a[l*WIDTH +: WIDTH], b[l*WIDTH +: WIDTH], c, z, il);
            e.c[l*WIDTH +: WIDTH] = c;
            e.zero[l] = z;
            e.ill[l]  = il;
        end
        return e;
    endfunction

    // Drive a beat, push its expectation when it will be accepted at the next
    // edge, and return just after that edge.
    task automatic send(input logic [LANES-1:0] en, input logic [LANES*5-1:0] op,
                        input logic [LANES*WIDTH-1:0] a, input logic [LANES*WIDTH-1:0] b,
                        input exp_t e);
        bit acc = 1'b0;
        in_valid   = 1'b1;
        in_lane_en = en;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                acc = 1'b1;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for 1000 cycles, op=%h", op);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic mk(input logic [LANES*WIDTH-1:0] c, input logic [LANES-1:0] z,
                      input logic [LANES-1:0] il, output exp_t e);
        e.c = c;
        e.zero = z;
        e.ill = il;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    // Monitor: compare every beat that transfers downstream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got out_c=%h with no expected beat queued", out_c);
            end else begin
                mon_e = sb.pop_front();
                check("out_c", out_c, mon_e.c);
                check("out_zero", 128'(out_zero), 128'(mon_e.zero));
                check("out_illegal", 128'(out_illegal), 128'(mon_e.ill));
            end
        end
    end

    // Random downstream readiness during streaming.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        exp_t e;
        logic [LANES*WIDTH-1:0] held;
        logic [LANES-1:0]       r_en;
        logic [LANES*5-1:0]     r_op;
        logic [LANES*WIDTH-1:0] r_a, r_b;

        rst_n = 1'b0; in_valid = 1'b0; in_lane_en = '0; in_op = '0;
        in_a = '0; in_b = '0; out_ready = 1'b1; err_clr = 1'b0;
        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_c", out_c, 128'd0);
        check("rst_err_count", 128'(err_count), 128'd0);

        // Single beat: lane0 AND, lane1 NEG 1.
        mk(64'hFFFFFFFF_F000F000, 2'b00, 2'b00, e);
        send(2'b11, {5'b10001, 5'b01010}, 64'h00000001_F0F0F0F0, 64'h00000000_FF00FF00, e);
        // lane0 NAND, lane1 ORN.
        mk(64'h00000000_00FFFFFF, 2'b10, 2'b00, e);
        send(2'b11, {5'b10011, 5'b01101}, 64'h00000000_FFFF0000, 64'hFFFFFFFF_FF00FF00, e);
        // lane0 PASSB, lane1 ANDN.
        mk(64'hF0F0F0F0_DEADBEEF, 2'b00, 2'b00, e);
        send(2'b11, {5'b10010, 5'b10101}, 64'hFFFFFFFF_00000000, 64'h0F0F0F0F_DEADBEEF, e);
        // lane0 XNOR 0,0, lane1 NOT all-ones.
        mk(64'h00000000_FFFFFFFF, 2'b10, 2'b00, e);
        send(2'b11, {5'b10000, 5'b01111}, 64'hFFFFFFFF_00000000, 64'h0, e);
        // lane0 OR, lane1 NOR 0,0.
        mk(64'hFFFFFFFF_0000F00F, 2'b00, 2'b00, e);
        send(2'b11, {5'b01110, 5'b01011}, 64'h00000000_0000F000, 64'h00000000_0000000F, e);
        // Boundaries: NEG 0x80000000, POPC all-ones.
        mk(64'h00000020_80000000, 2'b00, 2'b00, e);
        send(2'b11, {5'b10110, 5'b10001}, 64'hFFFFFFFF_80000000, 64'h0, e);
        // XOR a==b and NEG 0 both give zero.
        mk(64'h0, 2'b11, 2'b00, e);
        send(2'b11, {5'b10001, 5'b01100}, 64'h00000000_12345678, 64'h00000000_12345678, e);
        drain();
        check("err_after_legal", 128'(err_count), 128'd0);

        // Illegal lane0, disabled lane1.
        mk(64'h0, 2'b00, 2'b01, e);
        send(2'b01, {5'b01010, 5'b11111}, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, e);
        check("err_one", 128'(err_count), 128'd1);
        for (int i = 0; i < 299; i++) begin
            send(2'b01, {5'b01010, 5'b11111}, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, e);
        end
        check("err_saturate", 128'(err_count), 128'hFF);
        drain();

        // Clear wins over a simultaneous illegal accept.
        err_clr = 1'b1;
        send(2'b01, {5'b01010, 5'b11111}, 64'h1, 64'h1, e);
        err_clr = 1'b0;
        check("err_clr_prio", 128'(err_count), 128'd0);
        // Codes just outside the legal range; PASSA of zero beside illegal 00000.
        mk(64'h0, 2'b00, 2'b11, e);
        send(2'b11, {5'b01001, 5'b10111}, 64'h5, 64'h5, e);
        mk(64'h0, 2'b01, 2'b10, e);
        send(2'b11, {5'b00000, 5'b10100}, 64'h0, 64'h0, e);
        check("err_two", 128'(err_count), 128'd2);
        drain();

        // Backpressure: stage full, second beat held off, outputs stable.
        out_ready = 1'b0;
        mk(64'h00000001_00000003, 2'b00, 2'b00, e);
        send(2'b11, {5'b10100, 5'b10110}, 64'h00000001_00000007, 64'h0, e);
        held = out_c;
        fork
            begin
                mk(64'hAAAAAAAA_55555555, 2'b00, 2'b00, e);
                send(2'b11, {5'b10101, 5'b10101}, 64'h0, 64'hAAAAAAAA_55555555, e);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 128'(in_ready), 128'd0);
                    check("bp_out_valid", 128'(out_valid), 128'd1);
                    check("bp_out_c_stable", out_c, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_second_presented", 128'(out_valid), 128'd1);
        drain();

        // Reset while stalled drops the held beat immediately.
        out_ready = 1'b0;
        mk(64'h1, 2'b00, 2'b00, e);
        send(2'b01, {5'b10100, 5'b10100}, 64'h1, 64'h0, e);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 128'(out_valid), 128'd0);
        check("rst_async_c", out_c, 128'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;

        // Streaming with random gaps and random downstream readiness.
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            for (int l = 0; l < LANES; l++) begin
                r_op[l*5 +: 5]         = 5'($urandom_range(8, 24));
                r_a[l*WIDTH +: WIDTH]  = $urandom;
                r_b[l*WIDTH +: WIDTH]  = ($urandom_range(0, 7) == 0) ? r_a[l*WIDTH +: WIDTH] : $urandom;
            end
            r_en = LANES'($urandom);
            send(r_en, r_op, r_a, r_b, ref_beat(r_en, r_op, r_a, r_b));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
